// File: rtl/psys_route_pkg.sv
// Shared constants for the data-route switch width converters.
// The 1536->128 down-converters and this 128->1536 packer agree on
// lane width, lane count and the LSB-first lane numbering.
package psys_route_pkg;

  localparam int LANE_W = 128;
  localparam int NLANE  = 12;
  localparam int WIDE_W = LANE_W * NLANE;

  // Lane index within a wide word (0..11 used).
  typedef logic [3:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = 4'd11;

  // Mask with lanes 0..top set; lanes above top cleared.
  function automatic logic [NLANE-1:0] lanes_up_to(input lane_idx_t top);
    logic [NLANE-1:0] m;
    m = '0;
    for (int k = 0; k < NLANE; k++) begin
      if (lane_idx_t'(k) <= top) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/in128_out1536_pack.sv
// 128-bit to 1536-bit AXI-Stream packer for the switch return path.
// Beats fill lanes LSB-first; the twelfth beat or a tlast beat closes
// the word, which moves into a single registered output stage together
// with a lane-valid mask. Lanes that received no beat are driven to 0.
module in128_out1536_pack
  import psys_route_pkg::*;
#(
  parameter int LWIDTH = LANE_W,
  parameter int NLANE  = psys_route_pkg::NLANE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LWIDTH-1:0]         s_in_tdata,
  input  logic                      s_in_tvalid,
  input  logic                      s_in_tlast,
  output logic                      s_in_tready,
  output logic [NLANE*LWIDTH-1:0]   m_out_tdata,
  output logic [NLANE-1:0]          m_out_tkeep,
  output logic                      m_out_tlast,
  output logic                      m_out_tvalid,
  input  logic                      m_out_tready
);

  logic [NLANE*LWIDTH-1:0] acc;
  lane_idx_t               cnt;

  logic                    accept;
  logic                    closing;
  logic [NLANE-1:0]        keep_next;
  logic [NLANE*LWIDTH-1:0] word_next;

  // Input is accepted whenever the output stage is empty or draining now.
  assign s_in_tready = ~rst & (~m_out_tvalid | m_out_tready);
  assign accept      = s_in_tvalid & s_in_tready;
  assign closing     = (cnt == LAST_LANE) | s_in_tlast;

  // Assemble the word that a closing beat would emit: acc with the beat in lane cnt, upper lanes zeroed.
  always_comb begin
    keep_next = lanes_up_to(cnt);
    word_next = acc;
    word_next[cnt*LWIDTH +: LWIDTH] = s_in_tdata;
    for (int k = 0; k < NLANE; k++) begin
      if (keep_next[k]) begin
        word_next[k*LWIDTH +: LWIDTH] = word_next[k*LWIDTH +: LWIDTH];
      end else begin
        word_next[k*LWIDTH +: LWIDTH] = '0;
      end
    end
  end

  // Accumulator and lane counter: fill lanes in order, restart after each closing beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= 4'd0;
    end else if (accept) begin
      if (closing) begin
        acc <= '0;
        cnt <= 4'd0;
      end else begin
        acc[cnt*LWIDTH +: LWIDTH] <= s_in_tdata;
        cnt <= cnt + 4'd1;
      end
    end else begin
      acc <= acc;
      cnt <= cnt;
    end
  end

  // Output stage: load on a closing beat (even while draining), otherwise clear valid on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out_tdata  <= '0;
      m_out_tkeep  <= '0;
      m_out_tlast  <= 1'b0;
      m_out_tvalid <= 1'b0;
    end else if (accept && closing) begin
      m_out_tdata  <= word_next;
      m_out_tkeep  <= keep_next;
      m_out_tlast  <= s_in_tlast;
      m_out_tvalid <= 1'b1;
    end else if (m_out_tready) begin
      m_out_tvalid <= 1'b0;
    end else begin
      m_out_tvalid <= m_out_tvalid;
    end
  end

endmodule

// File: tb/tb_in128_out1536_pack.sv
// Self-checking bench for in128_out1536_pack: a queue-based model of
// the packing rules is compared with the DUT every cycle, plus literal
// expectations for the directed scenarios.
module tb_in128_out1536_pack;

  logic           clk;
  logic           rst;
  logic [127:0]   s_in_tdata;
  logic           s_in_tvalid;
  logic           s_in_tlast;
  logic           s_in_tready;
  logic [1535:0]  m_out_tdata;
  logic [11:0]    m_out_tkeep;
  logic           m_out_tlast;
  logic           m_out_tvalid;
  logic           m_out_tready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  in128_out1536_pack dut (
    .clk          (clk),
    .rst          (rst),
    .s_in_tdata   (s_in_tdata),
    .s_in_tvalid  (s_in_tvalid),
    .s_in_tlast   (s_in_tlast),
    .s_in_tready  (s_in_tready),
    .m_out_tdata  (m_out_tdata),
    .m_out_tkeep  (m_out_tkeep),
    .m_out_tlast  (m_out_tlast),
    .m_out_tvalid (m_out_tvalid),
    .m_out_tready (m_out_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1535:0] act, input logic [1535:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: beats collected for the open word, and the word held at the output.
  logic [127:0]  part[$];
  logic [1535:0] mw_data;
  logic [11:0]   mw_keep;
  logic          mw_last;
  bit            m_full = 1'b0;
  int            hs_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_tready", {1535'd0, s_in_tready}, 1536'd0);
        chk("rst_valid", {1535'd0, m_out_tvalid}, 1536'd0);
        chk("rst_data", m_out_tdata, 1536'd0);
        chk("rst_keep", {1524'd0, m_out_tkeep}, 1536'd0);
        chk("rst_last", {1535'd0, m_out_tlast}, 1536'd0);
        part.delete();
        m_full = 1'b0;
      end else begin
        bit exp_rdy;
        exp_rdy = !m_full || m_out_tready;
        chk("tready", {1535'd0, s_in_tready}, {1535'd0, exp_rdy});
        chk("valid", {1535'd0, m_out_tvalid}, {1535'd0, m_full});
        if (m_full) begin
          chk("data", m_out_tdata, mw_data);
          chk("keep", {1524'd0, m_out_tkeep}, {1524'd0, mw_keep});
          chk("last", {1535'd0, m_out_tlast}, {1535'd0, mw_last});
        end
        // predict the coming rising edge
        if (m_full && m_out_tready) begin
          m_full = 1'b0;
          hs_cyc.push_back(cyc);
        end
        if (s_in_tvalid && exp_rdy) begin
          part.push_back(s_in_tdata);
          if (part.size() == 12 || s_in_tlast) begin
            logic [12:0] km;
            mw_data = '0;
            foreach (part[i]) mw_data[i*128 +: 128] = part[i];
            km = (13'd1 << part.size()) - 13'd1;
            mw_keep = km[11:0];
            mw_last = s_in_tlast;
            m_full = 1'b1;
            part.delete();
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_in_tdata  = d;
    s_in_tlast  = l;
    s_in_tvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = s_in_tready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    s_in_tvalid = 1'b0;
    s_in_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [127:0]  v;
    logic [1535:0] snap;
    rst = 1'b1;
    s_in_tdata = '0;
    s_in_tvalid = 1'b0;
    s_in_tlast = 1'b0;
    m_out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", {1535'd0, s_in_tready}, {1535'd0, 1'b1});
    @(posedge clk);
    #1;

    // 1: twelve beats, lane k = k replicated, tlast on the last
    for (int k = 0; k < 12; k++) send({16{8'(k)}}, (k == 11));
    s_in_tvalid = 1'b0;
    chk("t1_valid", {1535'd0, m_out_tvalid}, {1535'd0, 1'b1});
    chk("t1_keep", {1524'd0, m_out_tkeep}, {1524'd0, 12'hFFF});
    chk("t1_last", {1535'd0, m_out_tlast}, {1535'd0, 1'b1});
    v = {16{8'h05}};
    chk("t1_lane5", {1408'd0, m_out_tdata[5*128 +: 128]}, {1408'd0, v});
    v = {16{8'h0b}};
    chk("t1_lane11", {1408'd0, m_out_tdata[11*128 +: 128]}, {1408'd0, v});
    idle(2);

    // 2: 24 back-to-back beats, no tlast
    for (int k = 0; k < 24; k++) send({4{32'(k + 256)}}, 1'b0);
    idle(3);
    chk("t2_words", {1504'd0, 32'(hs_cyc.size())}, {1504'd0, 32'd3});
    if (hs_cyc.size() >= 2)
      chk("t2_interval", {1504'd0, 32'(hs_cyc[$] - hs_cyc[$-1])}, {1504'd0, 32'd12});

    // 3: five-beat short packet
    for (int k = 0; k < 5; k++) send({8{16'(k + 16'h0A00)}}, (k == 4));
    s_in_tvalid = 1'b0;
    chk("t3_keep", {1524'd0, m_out_tkeep}, {1524'd0, 12'h01F});
    chk("t3_upper_zero", m_out_tdata >> 640, 1536'd0);
    chk("t3_last", {1535'd0, m_out_tlast}, {1535'd0, 1'b1});
    idle(2);

    // 4: single tlast beat at lane 0
    v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    send(v, 1'b1);
    s_in_tvalid = 1'b0;
    chk("t4_keep", {1524'd0, m_out_tkeep}, {1524'd0, 12'h001});
    chk("t4_data", m_out_tdata, {1408'd0, v});
    idle(2);

    // 5: complete word held by backpressure for 10 cycles
    m_out_tready = 1'b0;
    for (int k = 0; k < 12; k++) send({4{32'(k + 32'h5000)}}, 1'b0);
    snap = m_out_tdata;
    v = 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF;
    s_in_tdata = v;
    s_in_tlast = 1'b1;
    s_in_tvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_tready", {1535'd0, s_in_tready}, 1536'd0);
      chk("bp_stable", m_out_tdata, snap);
    end
    @(posedge clk);
    #1 m_out_tready = 1'b1;
    send(v, 1'b1);
    s_in_tvalid = 1'b0;
    chk("t5_next_valid", {1535'd0, m_out_tvalid}, {1535'd0, 1'b1});
    chk("t5_next_data", m_out_tdata, {1408'd0, v});
    idle(2);

    // 6: reset after seven beats, then a fresh word
    for (int k = 0; k < 7; k++) send({4{32'(k + 32'h7700)}}, 1'b0);
    s_in_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) send({4{32'(k + 32'h9900)}}, 1'b0);
    s_in_tvalid = 1'b0;
    chk("t6_keep", {1524'd0, m_out_tkeep}, {1524'd0, 12'hFFF});
    chk("t6_last", {1535'd0, m_out_tlast}, 1536'd0);
    v = {4{32'h0000_9900}};
    chk("t6_lane0", {1408'd0, m_out_tdata[127:0]}, {1408'd0, v});
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
